module_sum_display_driver: RTL and testbench
============================================

// Module: module_sum_display_driver
// PURPOSE
//  Downstream stage of module_ripple_carry_adder. Captures the adder sum S on a strobe.
//  Converts the sum to packed BCD with a sequential double-dabble shifter.
//  Drives a time-multiplexed, active-low 7-segment display with leading-zero blanking.
// PARAMETERS
//  ANCHO        8     sum width in bits; legal range 1..16
//  NDIG         3     number of BCD digits; must satisfy 10**NDIG > 2**ANCHO-1
//  REFRESH_DIV  50000 clk cycles each digit stays lit; >=2 (sims use 4)
// PORTS
//  clk      in   1        single clock; all state updates on the rising edge
//  rst      in   1        synchronous, active-high reset
//  S_i      in   ANCHO    unsigned sum from module_ripple_carry_adder
//  valid_i  in   1        capture strobe for S_i; honoured only in IDLE
//  busy_o   out  1        high while in CONV or DONE
//  done_o   out  1        one-cycle pulse; bcd_o is updated on this same cycle
//  bcd_o    out  4*NDIG   packed BCD; digit 0 in [3:0]; held between conversions
//  an_o     out  NDIG     digit enables, active low, one-hot
//  seg_o    out  7        segments {g,f,e,d,c,b,a}, active low
// BEHAVIOUR
//  Reset (rst=1 at an edge): every register below takes its reset value on that edge.
//   - FSM=IDLE, bcd_o=0, done_o=0, busy_o=0
//   - refresh counter=0, digit index=0
//   - an_o=~1 (only digit 0 enabled), seg_o=7'b1000000 (glyph '0')
//  Reset mid-conversion aborts the conversion; nothing partial ever reaches bcd_o.
//  FSM states: IDLE -> CONV -> DONE -> IDLE.
//  IDLE:
//   - On valid_i=1: latch S_i into shift reg, clear BCD scratch, count=0, go to CONV.
//   - Otherwise remain in IDLE.
//  CONV, one step per cycle:
//   - For each scratch digit >=5, add 3 to it.
//   - Then shift {scratch,shift_reg} left by 1.
//   - count++; after ANCHO steps go to DONE.
//  DONE (exactly one cycle):
//   - bcd_o<=scratch, done_o=1, go to IDLE.
//  Latency: valid_i sampled at edge 0 -> done_o high in the cycle after edge ANCHO+1.
//  For ANCHO=8 that is 9 cycles; busy_o is high for ANCHO+1 cycles.
//  valid_i while busy_o=1 (including the DONE cycle) is ignored, not queued.
//  The next valid_i is accepted in the first IDLE cycle after done_o.
//  S_i is sampled only at the accept edge; later changes to S_i have no effect.
//  Arithmetic is unsigned; no overflow is possible given the NDIG constraint.
//  Display timing:
//   - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
//   - On wrap, digit index goes to index+1; NDIG-1 wraps to 0.
//   - an_o = ~(1<<index); seg_o is the registered decode of digit[index].
//   - an_o and seg_o always change on the same edge.
//  Display content:
//   - Decodes come from bcd_o, so the display changes only after done_o.
//   - Digit values 0..9 only; the 10..15 decode case is unreachable and drives blank.
//  Leading-zero blanking:
//   - A digit above digit 0 is blanked (seg_o=7'h7F) when it and all higher digits are 0.
//   - Digit 0 is never blanked.
//   - Zeros between nonzero digits are shown (107 shows "107").
// STRUCTURE
//  Package pkg_sum_display:
//   - typedef enum logic [1:0] {IDLE, CONV, DONE} state_t
//   - SEG_LUT[0:9] active-low glyph constants, SEG_BLANK = 7'h7F
//  Sub-module module_bin2bcd_seq, parameters ANCHO and NDIG:
//   - contains the FSM and double-dabble datapath
//   - drives busy_o, done_o, bcd_o
//  The top level adds the refresh counter, digit mux, blanking logic and seg decode.
// TESTING (ANCHO=8, NDIG=3, REFRESH_DIV=4)
//  1. Release reset -> an_o=3'b110, seg_o=7'b1000000, bcd_o=0, busy_o=0.
//  2. S_i=255, one-cycle valid_i -> done_o only in the cycle after edge 9, bcd_o=12'h255;
//     display scan shows 2, 5, 5.
//  3. S_i=107 -> bcd_o=12'h107; digit 1 displays '0', not blank.
//     S_i=7 -> bcd_o=12'h007; digits 2 and 1 blank.
//  4. S_i=0 -> bcd_o=0; only digit 0 lit, showing '0'.
//  5. valid_i held high with S_i changing during CONV and DONE -> one result per accept;
//     a second conversion starts only in the first IDLE cycle; results match S_i at accept.
//  6. rst pulsed in CONV after a prior bcd_o=12'h042 -> bcd_o=0, no done_o pulse, state IDLE.
//     Refresh: an_o steps 110->101->011->110 every 4 cycles.
//  Bench: exhaustive S_i 0..255, each checked against a $sformatf("%0d") reference.

Source files
------------

// File: rtl/module_sum_display_driver_pkg.sv
// Shared types and constants for the sum display driver.
//   state_t     : converter FSM states
//   SEG_LUT     : active-low glyphs for digits 0..9, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK   : all segments off
//   seg_decode  : digit -> glyph, anything above 9 decodes to blank
package pkg_sum_display;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        if (d <= 4'd9) begin
            return SEG_LUT[d];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/module_sum_display_driver_bin2bcd_seq.sv
// Sequential double-dabble binary to packed-BCD converter.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   S_i      : binary value, sampled only on the accept edge
//   valid_i  : start strobe, honoured only in IDLE
//   busy_o   : high in CONV and DONE
//   done_o   : one-cycle pulse, bcd_o updated on the same edge
//   bcd_o    : packed BCD result, digit 0 in [3:0], held between conversions
//
//   state | meaning
//   IDLE  | waiting for valid_i
//   CONV  | one add-3/shift step per cycle, ANCHO steps
//   DONE  | publish scratch to bcd_o, pulse done_o
module module_bin2bcd_seq
    import pkg_sum_display::*;
#(
    parameter int ANCHO = 8,
    parameter int NDIG  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ANCHO-1:0]  S_i,
    input  logic              valid_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [4*NDIG-1:0] bcd_o
);

    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(ANCHO + 1);

    state_t           state_q, state_d;
    logic [ANCHO-1:0] shift_q, shift_d;
    logic [BW-1:0]    scratch_q, scratch_d;
    logic [BW-1:0]    adj;
    logic [CW-1:0]    count_q, count_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             done_q, done_d;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;

        adj = scratch_q;
        for (int k = 0; k < NDIG; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    shift_d   = S_i;
                    scratch_d = '0;
                    count_d   = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                count_d = count_q + 1'b1;
                if (count_q == CW'(ANCHO - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q == CONV) || (state_q == DONE);
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/module_sum_display_driver.sv
// Captures an adder sum, converts it to BCD and scans it onto a multiplexed
// active-low 7-segment display with leading-zero blanking.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   S_i      : unsigned sum to display
//   valid_i  : capture strobe, ignored while busy_o
//   busy_o   : conversion in progress
//   done_o   : one-cycle pulse when bcd_o updates
//   bcd_o    : packed BCD of the last completed conversion
//   an_o     : digit enables, active low, one-hot
//   seg_o    : segments {g,f,e,d,c,b,a}, active low
module module_sum_display_driver
    import pkg_sum_display::*;
#(
    parameter int ANCHO       = 8,
    parameter int NDIG        = 3,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ANCHO-1:0]  S_i,
    input  logic              valid_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [4*NDIG-1:0] bcd_o,
    output logic [NDIG-1:0]   an_o,
    output logic [6:0]        seg_o
);

    localparam int BW = 4 * NDIG;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [RW-1:0]   refresh_q, refresh_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NDIG-1:0] an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic [BW-1:0]   upper;
    logic            blank;

    module_bin2bcd_seq #(
        .ANCHO (ANCHO),
        .NDIG  (NDIG)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .S_i     (S_i),
        .valid_i (valid_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o)
    );

    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end

        // The selected digit and everything above it, shifted down to [3:0].
        // If that whole slice is zero the digit is a leading zero.
        upper = bcd_o >> {idx_d, 2'b00};
        blank = (idx_d != '0) && (upper == '0);

        an_d  = ~(NDIG'(1) << idx_d);
        seg_d = blank ? SEG_BLANK : seg_decode(upper[3:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= '0;
            an_q      <= ~NDIG'(1);
            seg_q     <= SEG_LUT[0];
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;

endmodule

// File: tb/tb_module_sum_display_driver.sv
module tb_module_sum_display_driver;

    localparam int ANCHO       = 8;
    localparam int NDIG        = 3;
    localparam int REFRESH_DIV = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  S_i;
    logic        valid_i;
    logic        busy_o;
    logic        done_o;
    logic [11:0] bcd_o;
    logic [2:0]  an_o;
    logic [6:0]  seg_o;

    int n_cmp;
    int n_err;

    module_sum_display_driver #(
        .ANCHO       (ANCHO),
        .NDIG        (NDIG),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .S_i     (S_i),
        .valid_i (valid_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o),
        .an_o    (an_o),
        .seg_o   (seg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        string       s;
        logic [11:0] r;
        s = $sformatf("%0d", v);
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            r = {r[7:0], 4'(s[i] - 8'd48)};
        end
        return r;
    endfunction

    // Strobe valid_i for one cycle; lat = cycles from accept edge to done_o.
    task automatic run_conv(input logic [7:0] v, output int lat);
        @(negedge clk);
        S_i     = v;
        valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        S_i     = ~v;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            if (done_o) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Scan 12 cycles and check each lit digit's glyph.
    task automatic check_display(input string tag, input logic [6:0] e0,
                                 input logic [6:0] e1, input logic [6:0] e2);
        logic [2:0] seen;
        seen = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            case (an_o)
                3'b110: begin chk({tag, "_d0"}, seg_o, e0); seen[0] = 1'b1; end
                3'b101: begin chk({tag, "_d1"}, seg_o, e1); seen[1] = 1'b1; end
                3'b011: begin chk({tag, "_d2"}, seg_o, e2); seen[2] = 1'b1; end
                default: chk({tag, "_an_onehot"}, an_o, 3'b110);
            endcase
            @(negedge clk);
        end
        chk({tag, "_all_digits_scanned"}, seen, 3'b111);
    endtask

    initial begin
        int lat;
        int first_done, second_done, n_done;
        logic [11:0] bcd_first, bcd_second;
        logic [2:0] an_prev;
        int gap;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        S_i = '0;
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1. reset state
        chk("rst_an", an_o, 3'b110);
        chk("rst_seg", seg_o, 7'b1000000);
        chk("rst_bcd", bcd_o, 12'h000);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);

        // 2. 255: latency, result and scan
        run_conv(8'd255, lat);
        chk("lat_255", lat, 9);
        chk("bcd_255", bcd_o, 12'h255);
        @(negedge clk);
        chk("done_pulse_width", done_o, 1'b0);
        chk("busy_after_done", busy_o, 1'b0);
        check_display("disp_255", 7'h12, 7'h12, 7'h24);

        // 3. inner zero shown, leading zeros blanked
        run_conv(8'd107, lat);
        chk("bcd_107", bcd_o, 12'h107);
        check_display("disp_107", 7'h78, 7'h40, 7'h79);
        run_conv(8'd7, lat);
        chk("bcd_007", bcd_o, 12'h007);
        check_display("disp_007", 7'h78, 7'h7F, 7'h7F);

        // 4. zero
        run_conv(8'd0, lat);
        chk("bcd_000", bcd_o, 12'h000);
        check_display("disp_000", 7'h40, 7'h7F, 7'h7F);

        // 5. valid held high, S_i changing; S_i=77 only in the done cycle
        @(negedge clk);
        S_i = 8'd10;
        valid_i = 1'b1;
        @(posedge clk);
        first_done = -1; second_done = -1; n_done = 0;
        bcd_first = '0; bcd_second = '0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (done_o) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k;
                    bcd_first  = bcd_o;
                end else if (second_done < 0) begin
                    second_done = k;
                    bcd_second  = bcd_o;
                    valid_i     = 1'b0;
                end
            end
            if (k == 10) chk("busy_second_start", busy_o, 1'b1);
            S_i = (first_done == k) ? 8'd77 : 8'(200 + k);
        end
        valid_i = 1'b0;
        chk("held_first_lat", first_done, 9);
        chk("held_first_bcd", bcd_first, 12'h010);
        chk("held_second_lat", second_done, 19);
        chk("held_second_bcd", bcd_second, 12'h077);
        chk("held_done_count", n_done, 2);

        // 6. reset mid-conversion
        run_conv(8'd42, lat);
        chk("bcd_042", bcd_o, 12'h042);
        @(negedge clk);
        S_i = 8'd99;
        valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_abort", busy_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_bcd", bcd_o, 12'h000);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_an", an_o, 3'b110);
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done_o) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        chk("abort_bcd_held", bcd_o, 12'h000);

        // refresh cadence: 110 -> 101 -> 011 -> 110, 4 cycles each
        an_prev = an_o;
        gap = 0;
        while (an_o == an_prev && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        for (int t = 0; t < 3; t++) begin
            an_prev = an_o;
            gap = 0;
            while (an_o == an_prev && gap < 10) begin
                @(negedge clk);
                gap++;
            end
            chk("refresh_gap", gap, 4);
            chk("refresh_next", an_o, {an_prev[1:0], an_prev[2]});
        end

        // exhaustive against decimal string reference
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), lat);
            chk($sformatf("bcd_%0d", v), bcd_o, ref_bcd(v));
            chk($sformatf("lat_%0d", v), lat, 9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
